// File: rtl/ringosc_freq_ctrl.sv
// rtl/ringosc_freq_ctrl.sv - ring oscillator settle/measure sequencer with tap edge counter
module ringosc_freq_ctrl #(
  parameter int WINDOW_W      = 16,
  parameter int COUNT_W       = 16,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [WINDOW_W-1:0] window_len,
  input  logic                ring_tap,
  output logic                osc_en,
  output logic                busy,
  output logic                done,
  output logic [COUNT_W-1:0]  count,
  output logic                overflow
);

  // The cycle counter must span both the settle period and the longest window.
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int CW = (WINDOW_W > SW) ? WINDOW_W : SW;

  typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, DONE} state_t;

  state_t              state, state_nx;
  logic [WINDOW_W-1:0] win_q;
  logic [CW-1:0]       cyc;
  logic                s1, s2, s3;
  logic                tap_rise;
  logic                accept;
  logic                settle_last;
  logic                meas_last;

  assign tap_rise    = s2 & ~s3;
  assign settle_last = (cyc == CW'(SETTLE_CYCLES - 1));
  assign meas_last   = (cyc == (CW'(win_q) - CW'(1)));

  // Next-state decode plus the state-derived busy/done flags.
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    accept   = 1'b0;
    case (state)
      IDLE, DONE: begin
        done = (state == DONE);
        if (start) begin
          accept   = 1'b1;
          state_nx = (window_len == '0) ? DONE : SETTLE;
        end else begin
          state_nx = IDLE;
        end
      end
      SETTLE: begin
        busy = 1'b1;
        if (settle_last) state_nx = MEASURE;
      end
      MEASURE: begin
        busy = 1'b1;
        if (meas_last) state_nx = DONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, tap synchronizer, phase counter and the saturating edge counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      osc_en   <= 1'b0;
      s1       <= 1'b0;
      s2       <= 1'b0;
      s3       <= 1'b0;
      win_q    <= '0;
      cyc      <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      state  <= state_nx;
      // Registered so the loopback select never glitches on decode.
      osc_en <= (state_nx == SETTLE) || (state_nx == MEASURE);
      s1     <= ring_tap;
      s2     <= s1;
      s3     <= s2;
      if (accept) begin
        win_q    <= window_len;
        cyc      <= '0;
        count    <= '0;
        overflow <= 1'b0;
      end else begin
        case (state)
          SETTLE: cyc <= settle_last ? '0 : cyc + CW'(1);
          MEASURE: begin
            cyc <= cyc + CW'(1);
            // A rise arriving with the counter already full is a lost edge.
            if (tap_rise) begin
              if (&count) overflow <= 1'b1;
              else        count    <= count + COUNT_W'(1);
            end
          end
          default: cyc <= cyc;
        endcase
      end
    end
  end

endmodule
